// File: rtl/issue_dispatch_pkg.sv
// Shared configuration for the dispatch stage: reservation-station indices
// and micro-op field widths, so rename, dispatch and the reservation
// stations all pack the payload the same way.
package issue_dispatch_pkg;

    // log2 of the dispatch FIFO depth
    localparam int CONFIG_P_DISP_DEPTH = 2;

    // Downstream reservation stations, in one-hot bit order
    localparam int CONFIG_NUM_RS = 4;
    localparam int NCPU_RS_ALU   = 0;
    localparam int NCPU_RS_BRU   = 1;
    localparam int NCPU_RS_LSU   = 2;
    localparam int NCPU_RS_EPU   = 3;

    // Micro-op field widths
    localparam int OPC_ALU_W  = 16;
    localparam int OPC_BRU_W  = 8;
    localparam int OPC_LSU_W  = 8;
    localparam int OPC_EPU_W  = 8;
    localparam int FE_W       = 4;
    localparam int PC_W       = 56;
    localparam int IMM_W      = 32;
    localparam int PRS_W      = 6;
    localparam int RE_W       = 2;
    localparam int PRD_W      = 6;
    localparam int WE_W       = 1;
    localparam int ROB_ID_W   = 5;
    localparam int ROB_BANK_W = 2;

    // Packed payload width, derived from the fields above
    localparam int CONFIG_PAYLOAD_W =
        OPC_ALU_W + OPC_BRU_W + OPC_LSU_W + OPC_EPU_W +
        FE_W + PC_W + IMM_W +
        2 * PRS_W + RE_W +
        PRD_W + WE_W +
        ROB_ID_W + ROB_BANK_W;

endpackage

// File: rtl/issue_dispatch_disp_fifo_ptr.sv
// Head/tail pointer pair with a wrap bit above the index bits. Equal
// pointers mean empty; equal index bits with differing wrap bits mean full.
// Reusable by any power-of-two circular queue.
module issue_dispatch_disp_fifo_ptr #(
    parameter int P_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush_i,
    input  logic               push_i,
    input  logic               pop_i,
    output logic [P_DEPTH-1:0] head_idx_o,
    output logic [P_DEPTH-1:0] tail_idx_o,
    output logic               empty_o,
    output logic               full_o
);

    localparam logic [P_DEPTH:0] PTR_ONE = 1;

    logic [P_DEPTH:0] head_q, head_d;
    logic [P_DEPTH:0] tail_q, tail_d;

    // Next-state pointers: flush rewinds both, otherwise advance independently
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        head_d = head_q;
        tail_d = tail_q;
        if (flush_i) begin
            head_d = '0;
            tail_d = '0;
        end else begin
            if (push_i) tail_d = tail_q + PTR_ONE;
            if (pop_i)  head_d = head_q + PTR_ONE;
        end
    end

    // Pointer registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    assign head_idx_o = head_q[P_DEPTH-1:0];
    assign tail_idx_o = tail_q[P_DEPTH-1:0];
    assign empty_o    = (head_q == tail_q);
    assign full_o     = (head_q[P_DEPTH-1:0] == tail_q[P_DEPTH-1:0]) &&
                        (head_q[P_DEPTH] != tail_q[P_DEPTH]);

endmodule

// File: rtl/issue_dispatch.sv
// In-order dispatch buffer between rename and the issue reservation
// stations. Queues one micro-op per cycle and steers the head into the one
// reservation station selected by its one-hot rs_sel, stalling behind a full
// station. Optional same-cycle bypass on an empty FIFO: NCPU_DISP_BYPASS_EN.
module issue_dispatch #(
    parameter int CONFIG_P_DISP_DEPTH = issue_dispatch_pkg::CONFIG_P_DISP_DEPTH,
    parameter int CONFIG_NUM_RS       = issue_dispatch_pkg::CONFIG_NUM_RS,
    parameter int CONFIG_PAYLOAD_W    = issue_dispatch_pkg::CONFIG_PAYLOAD_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        rn_valid,
    output logic                        rn_ready,
    input  logic [CONFIG_NUM_RS-1:0]    rn_rs_sel,
    input  logic [CONFIG_PAYLOAD_W-1:0] rn_payload,
    input  logic [CONFIG_NUM_RS-1:0]    issue_rs_full,
    output logic [CONFIG_NUM_RS-1:0]    issue_push,
    output logic [CONFIG_PAYLOAD_W-1:0] issue_payload,
    output logic                        disp_empty
);

    localparam int DEPTH = 1 << CONFIG_P_DISP_DEPTH;

    logic [CONFIG_P_DISP_DEPTH-1:0] head_idx;
    logic [CONFIG_P_DISP_DEPTH-1:0] tail_idx;
    logic                           fifo_empty;
    logic                           fifo_full;

    logic [CONFIG_NUM_RS-1:0]       sel_mem_q [DEPTH];
    logic [CONFIG_PAYLOAD_W-1:0]    pay_mem_q [DEPTH];

    logic [CONFIG_NUM_RS-1:0]       head_sel;
    logic [CONFIG_PAYLOAD_W-1:0]    head_payload;
    logic                           head_blocked;
    logic                           fifo_pop;
    logic                           fifo_enq;
    logic                           byp_fire;

    assign head_sel     = sel_mem_q[head_idx];
    assign head_payload = pay_mem_q[head_idx];
    assign head_blocked = |(head_sel & issue_rs_full);

    // A head with rs_sel == 0 is not blocked and leaves as a silent bubble
    assign fifo_pop = ~fifo_empty & ~flush & ~head_blocked;

`ifdef NCPU_DISP_BYPASS_EN
    // Empty queue means no older op exists, so skipping the FIFO keeps order
    assign byp_fire = fifo_empty & rn_valid & ~flush & ~|(rn_rs_sel & issue_rs_full);
`else
    assign byp_fire = 1'b0;
`endif

    // Ready comes from registered pointers only; a full queue refuses even
    // when the head leaves in the same cycle
    assign rn_ready   = ~fifo_full;
    assign disp_empty = fifo_empty;
    assign fifo_enq   = rn_valid & rn_ready & ~flush & ~byp_fire;

    issue_dispatch_disp_fifo_ptr #(
        .P_DEPTH (CONFIG_P_DISP_DEPTH)
    ) u_ptr (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (flush),
        .push_i     (fifo_enq),
        .pop_i      (fifo_pop),
        .head_idx_o (head_idx),
        .tail_idx_o (tail_idx),
        .empty_o    (fifo_empty),
        .full_o     (fifo_full)
    );

    // Entry storage, written at the tail on enqueue
    always_ff @(posedge clk) begin
        // NOTE: entries are deliberately not reset; the pointers alone decide which are valid.
        if (fifo_enq) begin
            sel_mem_q[tail_idx] <= rn_rs_sel;
            pay_mem_q[tail_idx] <= rn_payload;
        end
    end

    // Push strobe and payload steering; payload always driven from a real source
    always_comb begin
        issue_push    = '0;
        issue_payload = head_payload;
        if (fifo_pop) begin
            issue_push = head_sel;
        end
        if (byp_fire) begin
            issue_push    = rn_rs_sel;
            issue_payload = rn_payload;
        end
    end

endmodule

// File: tb/tb_issue_dispatch.sv
// Scoreboard bench for issue_dispatch. A queue-level reference model predicts
// occupancy and dispatched ops; a separate monitor matches each DUT push
// against the predicted stream.
module tb_issue_dispatch;

    localparam int P     = issue_dispatch_pkg::CONFIG_P_DISP_DEPTH;
    localparam int NRS   = issue_dispatch_pkg::CONFIG_NUM_RS;
    localparam int PW    = issue_dispatch_pkg::CONFIG_PAYLOAD_W;
    localparam int DEPTH = 1 << P;

    logic           clk = 1'b0;
    logic           rst;
    logic           flush;
    logic           rn_valid;
    logic           rn_ready;
    logic [NRS-1:0] rn_rs_sel;
    logic [PW-1:0]  rn_payload;
    logic [NRS-1:0] issue_rs_full;
    logic [NRS-1:0] issue_push;
    logic [PW-1:0]  issue_payload;
    logic           disp_empty;

    typedef struct {
        logic [NRS-1:0] sel;
        logic [PW-1:0]  pay;
    } op_t;

    op_t model_q[$];
    op_t exp_q[$];
    int  checks   = 0;
    int  failures = 0;

    always #5 clk = ~clk;

    issue_dispatch dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .rn_valid      (rn_valid),
        .rn_ready      (rn_ready),
        .rn_rs_sel     (rn_rs_sel),
        .rn_payload    (rn_payload),
        .issue_rs_full (issue_rs_full),
        .issue_push    (issue_push),
        .issue_payload (issue_payload),
        .disp_empty    (disp_empty)
    );

    task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [PW-1:0] rand_payload();
        return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Reference model: a plain queue of ops; predicts at each negedge what
    // the coming edge does, and queues every op that must reach an RS.
    always @(negedge clk) begin
        op_t op;
        bit  bypass;
        bit  enq;
        if (rst) begin
            model_q.delete();
        end else begin
            check("rn_ready", PW'(rn_ready), PW'(model_q.size() < DEPTH));
            check("disp_empty", PW'(disp_empty), PW'(model_q.size() == 0));
            bypass = 1'b0;
`ifdef NCPU_DISP_BYPASS_EN
            if (model_q.size() == 0 && rn_valid && !flush && (rn_rs_sel & issue_rs_full) == '0) begin
                bypass = 1'b1;
                if (rn_rs_sel != '0) exp_q.push_back('{rn_rs_sel, rn_payload});
            end
`endif
            enq = rn_valid && (model_q.size() < DEPTH) && !flush && !bypass;
            if (!flush && model_q.size() > 0 && (model_q[0].sel & issue_rs_full) == '0) begin
                op = model_q.pop_front();
                if (op.sel != '0) exp_q.push_back(op);
            end
            if (flush) model_q.delete();
            else if (enq) model_q.push_back('{rn_rs_sel, rn_payload});
        end
    end

    // Monitor: consumes one expected op per observed push
    always @(negedge clk) begin
        op_t op;
        #1;
        if (!rst) begin
            if (issue_push != '0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_push", PW'(issue_push), PW'(0));
                end else begin
                    op = exp_q.pop_front();
                    check("push_sel", PW'(issue_push), PW'(op.sel));
                    check("push_payload", issue_payload, op.pay);
                end
            end else if (exp_q.size() != 0) begin
                op = exp_q.pop_front();
                check("missing_push", PW'(issue_push), PW'(op.sel));
            end
        end
    end

    // RN must never present a multi-hot rs_sel
    always @(negedge clk) begin
        if (!rst && rn_valid) begin
            assert ($onehot0(rn_rs_sel)) else $error("multi-hot rn_rs_sel %b", rn_rs_sel);
        end
    end

    task automatic step(input logic v, input logic [NRS-1:0] s, input logic [NRS-1:0] f, input logic fl);
        rn_valid      = v;
        rn_rs_sel     = s;
        rn_payload    = rand_payload();
        issue_rs_full = f;
        flush         = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic [NRS-1:0] f);
        for (int i = 0; i < n; i++) step(1'b0, '0, f, 1'b0);
    endtask

    initial begin
        logic [NRS-1:0] sel;
        rst = 1'b1; flush = 1'b0; rn_valid = 1'b0; rn_rs_sel = '0;
        rn_payload = '0; issue_rs_full = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_push", PW'(issue_push), PW'(0));
        check("reset_ready", PW'(rn_ready), PW'(1));
        check("reset_empty", PW'(disp_empty), PW'(1));
        rst = 1'b0;

        // Basic: three ops to three stations
        step(1'b1, 4'b0001, 4'b0000, 1'b0);
        step(1'b1, 4'b0010, 4'b0000, 1'b0);
        step(1'b1, 4'b0100, 4'b0000, 1'b0);
        idle(3, 4'b0000);
        check("basic_drained", PW'(disp_empty), PW'(1));

        // Head-of-line block: LSU full holds the ALU op behind it
        step(1'b1, 4'b0100, 4'b0100, 1'b0);
        step(1'b1, 4'b0001, 4'b0100, 1'b0);
        idle(5, 4'b0100);
        check("hol_blocked_push", PW'(issue_push), PW'(0));
        idle(4, 4'b0000);

        // Backpressure: all stations full, six ops offered
        for (int i = 0; i < 6; i++) step(1'b1, 4'b1000 >> (i % 4), 4'b1111, 1'b0);
        check("full_not_ready", PW'(rn_ready), PW'(0));
        idle(6, 4'b0000);

        // Wrap: twenty ops with a full stall every third cycle
        for (int i = 0; i < 20; i++)
            step(1'b1, 4'b0001 << (i % 4), (i % 3 == 2) ? 4'b1111 : 4'b0000, 1'b0);
        idle(6, 4'b0000);

        // Flush with three queued ops and a valid op in the flush cycle
        for (int i = 0; i < 3; i++) step(1'b1, 4'b0001, 4'b1111, 1'b0);
        step(1'b1, 4'b0010, 4'b0000, 1'b1);
        check("flush_empty", PW'(disp_empty), PW'(1));
        check("flush_ready", PW'(rn_ready), PW'(1));
        idle(3, 4'b0000);

        // Async reset between edges with two queued ops
        step(1'b1, 4'b0001, 4'b1111, 1'b0);
        step(1'b1, 4'b0010, 4'b1111, 1'b0);
        rn_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("areset_push", PW'(issue_push), PW'(0));
        check("areset_ready", PW'(rn_ready), PW'(1));
        check("areset_empty", PW'(disp_empty), PW'(1));
        @(posedge clk);
        #1 rst = 1'b0;
        issue_rs_full = '0;
        idle(2, 4'b0000);

        // Randomized traffic: bubbles, random backpressure, occasional flush
        for (int i = 0; i < 400; i++) begin
            sel = ($urandom_range(9) == 0) ? 4'b0000 : (4'b0001 << $urandom_range(3));
            step($urandom_range(3) != 0, sel,
                 ($urandom_range(2) == 0) ? 4'($urandom()) : 4'b0000,
                 $urandom_range(29) == 0);
        end
        idle(10, 4'b0000);
        check("scoreboard_drained", PW'(exp_q.size()), PW'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
